uart_transmitter: RTL

//   Serialises one byte per frame onto the UART line: start(0), 8 data bits LSB first,

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_transmitter.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states, data width and default oversample rate.
package uart_pkg;

  localparam int unsigned DATA_BITS          = 8;
  localparam int unsigned OVERSAMPLE_DEFAULT = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Even parity makes the total count of ones even; odd parity inverts it.
  function automatic logic parity_of(input logic [DATA_BITS-1:0] data, input logic odd);
    return odd ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_transmitter.sv
// UART transmitter: start, 8 data bits LSB first, parity, STOP_BITS stop bits.
// A one-entry holding register lets the host queue the next byte mid-frame, so
// frames can run back to back with no idle gap on the line.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEFAULT,
  parameter bit          PARITY_ODD = 1'b0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 sys_clk,
  input  logic                 reset,
  input  logic                 baud_clk,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_out,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int unsigned TICK_W    = $clog2(OVERSAMPLE) + 1;
  localparam int unsigned BIT_CNT_W = $clog2(DATA_BITS);

  localparam logic [TICK_W-1:0]    BIT_LAST  = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0]    STOP_LAST = TICK_W'(STOP_BITS * OVERSAMPLE - 1);
  localparam logic [BIT_CNT_W-1:0] DATA_LAST = BIT_CNT_W'(DATA_BITS - 1);

  uart_state_e            state;
  logic [DATA_BITS-1:0]   hold;
  logic                   hold_full;
  logic [DATA_BITS-1:0]   shift_reg;
  logic                   parity_bit;
  logic [TICK_W-1:0]      tick_cnt;
  logic [BIT_CNT_W-1:0]   bit_cnt;

  logic accept_c;
  logic load_c;

  // Host handshake; tx_ready mirrors an empty holding register.
  assign accept_c = tx_valid && tx_ready;

  // Move the held byte into the shifter: from idle, or on the last stop tick.
  assign load_c = baud_clk && hold_full &&
                  ((state == ST_IDLE) || ((state == ST_STOP) && (tick_cnt == STOP_LAST)));

  // Holding register and frame sequencer; the line advances only on baud ticks.
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      hold       <= '0;
      hold_full  <= 1'b0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      tx_ready   <= 1'b1;
      tx_out     <= 1'b1;
      busy       <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      tx_done <= 1'b0;

      if (accept_c) begin
        hold      <= tx_data;
        hold_full <= 1'b1;
        tx_ready  <= 1'b0;
      end

      if (baud_clk) begin
        unique case (state)
          ST_IDLE: begin
            tx_out <= 1'b1;
          end

          ST_START: begin
            if (tick_cnt == BIT_LAST) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              tx_out   <= shift_reg[0];
              state    <= ST_DATA;
            end else begin
              tick_cnt <= tick_cnt + TICK_W'(1);
            end
          end

          ST_DATA: begin
            if (tick_cnt == BIT_LAST) begin
              tick_cnt <= '0;
              if (bit_cnt == DATA_LAST) begin
                tx_out <= parity_bit;
                state  <= ST_PARITY;
              end else begin
                bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                tx_out  <= shift_reg[bit_cnt + BIT_CNT_W'(1)];
              end
            end else begin
              tick_cnt <= tick_cnt + TICK_W'(1);
            end
          end

          ST_PARITY: begin
            if (tick_cnt == BIT_LAST) begin
              tick_cnt <= '0;
              tx_out   <= 1'b1;
              state    <= ST_STOP;
            end else begin
              tick_cnt <= tick_cnt + TICK_W'(1);
            end
          end

          ST_STOP: begin
            if (tick_cnt == STOP_LAST) begin
              tick_cnt <= '0;
              tx_done  <= 1'b1;
              busy     <= 1'b0;
              state    <= ST_IDLE;
            end else begin
              tick_cnt <= tick_cnt + TICK_W'(1);
            end
          end

          default: begin
            state  <= ST_IDLE;
            tx_out <= 1'b1;
            busy   <= 1'b0;
          end
        endcase
      end

      // A load overrides the idle/stop decisions above and starts a new frame.
      if (load_c) begin
        shift_reg  <= hold;
        parity_bit <= parity_of(hold, PARITY_ODD);
        hold_full  <= 1'b0;
        tx_ready   <= 1'b1;
        tx_out     <= 1'b0;
        busy       <= 1'b1;
        tick_cnt   <= '0;
        state      <= ST_START;
      end
    end
  end

endmodule
